// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester arbiter owning a shared 2:1 mux,
// with bounded grant slots and a registered, valid-tagged output.
module mux_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int SLOT  = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             sel,
  output logic             gnt_x,
  output logic             gnt_y,
  output logic [WIDTH-1:0] m,
  output logic             m_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } state_t;

  localparam logic [3:0] SLOT_C = 4'(SLOT);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       slot_end;

  assign slot_end = (cnt == SLOT_C);

  // last: 1 means Y held the datapath most recently, so X wins a tie
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      gnt_x   <= 1'b0;
      gnt_y   <= 1'b0;
      sel     <= 1'b0;
      cnt     <= 4'd0;
      last    <= 1'b1;
      m       <= '0;
      m_valid <= 1'b0;
    end else begin
      m       <= gnt_y ? y : x;
      m_valid <= (gnt_x & req_x) | (gnt_y & req_y);
      unique case (state)
        IDLE: begin
          if (req_x && (!req_y || last)) begin
            state <= GX;
            gnt_x <= 1'b1;
            gnt_y <= 1'b0;
            sel   <= 1'b0;
            cnt   <= 4'd1;
            last  <= 1'b0;
          end else if (req_y) begin
            state <= GY;
            gnt_x <= 1'b0;
            gnt_y <= 1'b1;
            sel   <= 1'b1;
            cnt   <= 4'd1;
            last  <= 1'b1;
          end
        end
        GX: begin
          if (req_x && !slot_end) begin
            cnt <= cnt + 4'd1;
          end else if (req_y) begin
            state <= GY;
            gnt_x <= 1'b0;
            gnt_y <= 1'b1;
            sel   <= 1'b1;
            cnt   <= 4'd1;
            last  <= 1'b1;
          end else if (req_x) begin
            cnt  <= 4'd1;
            last <= 1'b0;
          end else begin
            state <= IDLE;
            gnt_x <= 1'b0;
            cnt   <= 4'd0;
          end
        end
        GY: begin
          if (req_y && !slot_end) begin
            cnt <= cnt + 4'd1;
          end else if (req_x) begin
            state <= GX;
            gnt_x <= 1'b1;
            gnt_y <= 1'b0;
            sel   <= 1'b0;
            cnt   <= 4'd1;
            last  <= 1'b0;
          end else if (req_y) begin
            cnt  <= 4'd1;
            last <= 1'b1;
          end else begin
            state <= IDLE;
            gnt_y <= 1'b0;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          gnt_x <= 1'b0;
          gnt_y <= 1'b0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: directed vectors queue
// expected outputs; a negedge monitor pops and compares.
module tb_mux_share_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       reset, req_x, req_y;
  logic [7:0] x, y;
  logic       sel, gnt_x, gnt_y, m_valid;
  logic [7:0] m;
  logic       sel1, gnt_x1, gnt_y1, m_valid1;
  logic [7:0] m1;

  always #5 CLOCK_50 = ~CLOCK_50;

  mux_share_arbiter #(.WIDTH(8), .SLOT(4)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req_x(req_x), .req_y(req_y), .x(x), .y(y),
    .sel(sel), .gnt_x(gnt_x), .gnt_y(gnt_y),
    .m(m), .m_valid(m_valid)
  );

  mux_share_arbiter #(.WIDTH(8), .SLOT(1)) u_dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req_x(req_x), .req_y(req_y), .x(x), .y(y),
    .sel(sel1), .gnt_x(gnt_x1), .gnt_y(gnt_y1),
    .m(m1), .m_valid(m_valid1)
  );

  typedef struct {
    string      n;
    logic       gx, gy, s, mv;
    logic [7:0] m;
    logic       c1;
    logic       gx1, gy1, s1, mv1;
    logic [7:0] m1;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nbad = 0;

  function automatic exp_t e0(input string n,
                              input logic gx, gy, s, mv,
                              input logic [7:0] mm);
    exp_t r;
    r.n = n; r.gx = gx; r.gy = gy; r.s = s; r.mv = mv; r.m = mm;
    r.c1 = 1'b0; r.gx1 = 1'b0; r.gy1 = 1'b0;
    r.s1 = 1'b0; r.mv1 = 1'b0; r.m1 = 8'h00;
    return r;
  endfunction

  function automatic exp_t ez(input string n);
    exp_t r;
    r = e0(n, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    r.c1 = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r, rx, ry,
                      input logic [7:0] xv, yv,
                      input exp_t e);
    reset = r; req_x = rx; req_y = ry; x = xv; y = yv;
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
  endtask

  always @(negedge CLOCK_50) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ncmp++;
      if ({gnt_x, gnt_y, sel, m_valid, m} !==
          {e.gx, e.gy, e.s, e.mv, e.m}) begin
        nbad++;
        $display("FAIL %s: got gx=%b gy=%b sel=%b mv=%b m=%h want gx=%b gy=%b sel=%b mv=%b m=%h",
                 e.n, gnt_x, gnt_y, sel, m_valid, m,
                 e.gx, e.gy, e.s, e.mv, e.m);
      end
      if (e.c1) begin
        ncmp++;
        if ({gnt_x1, gnt_y1, sel1, m_valid1, m1} !==
            {e.gx1, e.gy1, e.s1, e.mv1, e.m1}) begin
          nbad++;
          $display("FAIL %s/slot1: got gx=%b gy=%b sel=%b mv=%b m=%h want gx=%b gy=%b sel=%b mv=%b m=%h",
                   e.n, gnt_x1, gnt_y1, sel1, m_valid1, m1,
                   e.gx1, e.gy1, e.s1, e.mv1, e.m1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req_x = 1'b0; req_y = 1'b0; x = 8'h00; y = 8'h00;

    step(1, 0, 0, 8'h00, 8'h00, ez("rst0"));
    step(1, 0, 0, 8'h00, 8'h00, ez("rst1"));
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 8'h00, 8'h00, e0("idle", 0, 0, 0, 0, 8'h00));

    // lone X: continuous grant, slot re-arms without a gap
    step(0, 1, 0, 8'hA5, 8'h00, e0("solo1", 1, 0, 0, 0, 8'hA5));
    for (int i = 0; i < 9; i++)
      step(0, 1, 0, 8'hA5, 8'h00, e0("solo", 1, 0, 0, 1, 8'hA5));
    step(0, 0, 0, 8'hA5, 8'h00, e0("solo_drop", 0, 0, 0, 0, 8'hA5));
    step(0, 0, 0, 8'h00, 8'h00, e0("solo_idle", 0, 0, 0, 0, 8'h00));

    // tie from reset: X 1-4, Y 5-8, X 9-12, Y 13
    step(1, 0, 0, 8'h00, 8'h00, ez("rst_tie"));
    for (int k = 1; k <= 13; k++) begin
      logic own, pown;
      own  = ((k - 1) / 4) % 2 == 1;
      pown = (k > 1) && (((k - 2) / 4) % 2 == 1);
      step(0, 1, 1, 8'h11, 8'h22,
           e0("tie", !own, own, own, k > 1,
              (k > 1 && pown) ? 8'h22 : 8'h11));
    end
    step(0, 0, 0, 8'h11, 8'h22, e0("tie_drop", 0, 0, 1, 0, 8'h22));
    step(0, 0, 0, 8'h00, 8'h00, e0("tie_hold", 0, 0, 1, 0, 8'h00));

    // early release of X hands straight to Y
    step(1, 0, 0, 8'h00, 8'h00, ez("rst_er"));
    step(0, 1, 1, 8'h33, 8'h44, e0("er_g1", 1, 0, 0, 0, 8'h33));
    step(0, 1, 1, 8'h33, 8'h44, e0("er_g2", 1, 0, 0, 1, 8'h33));
    step(0, 0, 1, 8'h33, 8'h44, e0("er_sw", 0, 1, 1, 0, 8'h33));
    step(0, 0, 1, 8'h33, 8'h44, e0("er_y", 0, 1, 1, 1, 8'h44));

    // reset while Y holds with cnt=2
    step(1, 1, 1, 8'h33, 8'h44, ez("mr_rst"));
    step(0, 1, 1, 8'h33, 8'h44, e0("mr_x", 1, 0, 0, 0, 8'h33));
    step(0, 1, 1, 8'h33, 8'h44, e0("mr_x2", 1, 0, 0, 1, 8'h33));
    step(0, 0, 0, 8'h33, 8'h44, e0("mr_drop", 0, 0, 0, 0, 8'h33));

    // SLOT=1 instance alternates every cycle
    step(1, 0, 0, 8'h00, 8'h00, ez("rst_s1"));
    for (int k = 1; k <= 8; k++) begin
      exp_t e;
      logic own, pown, own1, pown1;
      own   = ((k - 1) / 4) % 2 == 1;
      pown  = (k > 1) && (((k - 2) / 4) % 2 == 1);
      own1  = ((k - 1) % 2) == 1;
      pown1 = (k > 1) && (((k - 2) % 2) == 1);
      e = e0("s1", !own, own, own, k > 1,
             pown ? 8'h66 : 8'h55);
      e.c1  = 1'b1;
      e.gx1 = !own1;
      e.gy1 = own1;
      e.s1  = own1;
      e.mv1 = k > 1;
      e.m1  = pown1 ? 8'h66 : 8'h55;
      step(0, 1, 1, 8'h55, 8'h66, e);
    end

    repeat (2) @(negedge CLOCK_50);
    #1;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
